// File: rtl/fifo_ptr_status.sv
// rtl/fifo_ptr_status.sv - FIFO write/read pointers, occupancy, status flags and sticky error flags
module fifo_ptr_status #(
    parameter int ADDR_W = 4,
    parameter int THRESH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_we,
    input  logic              fifo_rd,
    input  logic              overflow_set,
    input  logic              underflow_set,
    input  logic              err_clr,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rbit,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_threshold,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] THRESH_V = (ADDR_W+1)'(THRESH);

    // Strobes against a full/empty FIFO are dropped here as well as upstream,
    // so the pointers can never cross each other even if the controller misbehaves.
    logic wr_accept;
    logic rd_accept;

    assign wr_accept = fifo_we & ~fifo_full;
    assign rd_accept = fifo_rd & ~fifo_empty;

    // Status is decoded purely from the registered pointers: the controller gates
    // its strobes with these flags, so no input may reach them combinationally.
    assign fifo_level     = wptr - rbit;
    assign fifo_empty     = (wptr == rbit);
    assign fifo_full      = (wptr[ADDR_W] != rbit[ADDR_W]) &&
                            (wptr[ADDR_W-1:0] == rbit[ADDR_W-1:0]);
    assign fifo_threshold = (fifo_level >= THRESH_V);

    // Write pointer advances on each accepted write; the MSB toggles on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
        end else if (wr_accept) begin
            wptr <= wptr + PTR_ONE;
        end
    end

    // Read pointer advances on each accepted read; the MSB toggles on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbit <= '0;
        end else if (rd_accept) begin
            rbit <= rbit + PTR_ONE;
        end
    end

    // Sticky error flags: a set pulse wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (overflow_set) begin
                fifo_overflow <= 1'b1;
            end else if (err_clr) begin
                fifo_overflow <= 1'b0;
            end
            if (underflow_set) begin
                fifo_underflow <= 1'b1;
            end else if (err_clr) begin
                fifo_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ptr_status.sv
// tb/tb_fifo_ptr_status.sv - self-checking bench for fifo_ptr_status
module tb_fifo_ptr_status;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int THRESH = 8;
    localparam int PMOD   = 2 * DEPTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_we = 1'b0;
    logic              fifo_rd = 1'b0;
    logic              overflow_set = 1'b0;
    logic              underflow_set = 1'b0;
    logic              err_clr = 1'b0;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rbit;
    logic [ADDR_W:0]   fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_threshold;
    logic              fifo_overflow;
    logic              fifo_underflow;

    fifo_ptr_status #(.ADDR_W(ADDR_W), .THRESH(THRESH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_we        (fifo_we),
        .fifo_rd        (fifo_rd),
        .overflow_set   (overflow_set),
        .underflow_set  (underflow_set),
        .err_clr        (err_clr),
        .wptr           (wptr),
        .rbit           (rbit),
        .fifo_level     (fifo_level),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy as a plain count, pointers as write/read totals mod 2*DEPTH
    int m_level = 0;
    int m_wcnt  = 0;
    int m_rcnt  = 0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;

    typedef struct {
        bit we;
        bit rd;
        bit ov;
        bit un;
        bit clr;
        int wp;
        int rp;
        int level;
        bit full;
        bit empty;
        bit thr;
        bit ovf;
        bit unf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " wptr"},      int'(wptr),           m_wcnt);
        chk({tag, " rbit"},      int'(rbit),           m_rcnt);
        chk({tag, " level"},     int'(fifo_level),     m_level);
        chk({tag, " full"},      int'(fifo_full),      int'(m_level == DEPTH));
        chk({tag, " empty"},     int'(fifo_empty),     int'(m_level == 0));
        chk({tag, " threshold"}, int'(fifo_threshold), int'(m_level >= THRESH));
        chk({tag, " overflow"},  int'(fifo_overflow),  int'(m_ovf));
        chk({tag, " underflow"}, int'(fifo_underflow), int'(m_unf));
    endtask

    task automatic step(input bit we, input bit rd, input bit ov, input bit un, input bit clr);
        bit acc_w;
        bit acc_r;
        fifo_we       = we;
        fifo_rd       = rd;
        overflow_set  = ov;
        underflow_set = un;
        err_clr       = clr;
        @(posedge clk);
        #1;
        acc_w   = we && (m_level < DEPTH);
        acc_r   = rd && (m_level > 0);
        m_level = m_level + int'(acc_w) - int'(acc_r);
        m_wcnt  = (m_wcnt + int'(acc_w)) % PMOD;
        m_rcnt  = (m_rcnt + int'(acc_r)) % PMOD;
        if (ov) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (un) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        fifo_we       = 1'b0;
        fifo_rd       = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        err_clr       = 1'b0;
    endtask

    task automatic model_reset();
        m_level = 0;
        m_wcnt  = 0;
        m_rcnt  = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic do_reset();
        fifo_we       = 1'b0;
        fifo_rd       = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        err_clr       = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // we rd ov un clr | wptr rbit level full empty thr ovf unf
        tbl[0] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{1, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 0, 0, 3, 2, 1, 0, 0, 0, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 1, 3, 2, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 1, 1, 3, 2, 1, 0, 0, 0, 0, 1};
        tbl[8] = '{0, 0, 0, 0, 1, 3, 2, 1, 0, 0, 0, 0, 0};
        tbl[9] = '{1, 0, 0, 0, 0, 4, 2, 2, 0, 0, 0, 0, 0};

        // Reset state
        do_reset();
        chk("reset wptr",      int'(wptr),           0);
        chk("reset rbit",      int'(rbit),           0);
        chk("reset level",     int'(fifo_level),     0);
        chk("reset empty",     int'(fifo_empty),     1);
        chk("reset full",      int'(fifo_full),      0);
        chk("reset threshold", int'(fifo_threshold), 0);
        chk("reset overflow",  int'(fifo_overflow),  0);
        chk("reset underflow", int'(fifo_underflow), 0);

        // Table-driven short sequence from reset
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].we, tbl[i].rd, tbl[i].ov, tbl[i].un, tbl[i].clr);
            chk($sformatf("tbl%0d wptr", i),      int'(wptr),           tbl[i].wp);
            chk($sformatf("tbl%0d rbit", i),      int'(rbit),           tbl[i].rp);
            chk($sformatf("tbl%0d level", i),     int'(fifo_level),     tbl[i].level);
            chk($sformatf("tbl%0d full", i),      int'(fifo_full),      int'(tbl[i].full));
            chk($sformatf("tbl%0d empty", i),     int'(fifo_empty),     int'(tbl[i].empty));
            chk($sformatf("tbl%0d threshold", i), int'(fifo_threshold), int'(tbl[i].thr));
            chk($sformatf("tbl%0d overflow", i),  int'(fifo_overflow),  int'(tbl[i].ovf));
            chk($sformatf("tbl%0d underflow", i), int'(fifo_underflow), int'(tbl[i].unf));
        end

        // 16 writes from empty, then drain; three fill/drain passes across the wrap
        do_reset();
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 1; i <= DEPTH; i++) begin
                step(1, 0, 0, 0, 0);
                check_model($sformatf("fill p%0d w%0d", pass, i));
                if (pass == 0 && i == THRESH - 1) chk("thr before 8th write", int'(fifo_threshold), 0);
                if (pass == 0 && i == THRESH)     chk("thr after 8th write",  int'(fifo_threshold), 1);
            end
            chk($sformatf("full p%0d", pass),  int'(fifo_full),  1);
            chk($sformatf("level16 p%0d", pass), int'(fifo_level), DEPTH);
            chk($sformatf("wptr at full p%0d", pass), int'(wptr), ((pass + 1) * DEPTH) % PMOD);
            for (int i = 1; i <= DEPTH; i++) begin
                step(0, 1, 0, 0, 0);
                check_model($sformatf("drain p%0d r%0d", pass, i));
            end
            chk($sformatf("empty p%0d", pass), int'(fifo_empty), 1);
            chk($sformatf("rbit at empty p%0d", pass), int'(rbit), ((pass + 1) * DEPTH) % PMOD);
        end

        // Level 7 with 20 simultaneous write+read cycles
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 0);
            chk("simul level", int'(fifo_level), 7);
            chk("simul thr",   int'(fifo_threshold), 0);
        end
        chk("simul wptr", int'(wptr), 27);
        chk("simul rbit", int'(rbit), 20);

        // Write while full is ignored; write+read at full takes only the read
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("we at full wptr", int'(wptr), DEPTH);
        chk("we at full level", int'(fifo_level), DEPTH);
        step(1, 1, 0, 0, 0);
        chk("we+rd at full level", int'(fifo_level), DEPTH - 1);
        chk("we+rd at full full",  int'(fifo_full), 0);
        chk("we+rd at full wptr",  int'(wptr), DEPTH);
        // Read while empty is ignored; write+read at empty takes only the write
        do_reset();
        step(0, 1, 0, 0, 0);
        chk("rd at empty rbit", int'(rbit), 0);
        chk("rd at empty wptr", int'(wptr), 0);
        step(1, 1, 0, 0, 0);
        chk("we+rd at empty level", int'(fifo_level), 1);
        chk("we+rd at empty rbit",  int'(rbit), 0);

        // Sticky overflow held, cleared; underflow set wins over clear
        do_reset();
        step(0, 0, 1, 0, 0);
        chk("ovf after pulse", int'(fifo_overflow), 1);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0);
            chk("ovf held", int'(fifo_overflow), 1);
        end
        chk("ovf ptr hold", int'(wptr), 0);
        step(0, 0, 0, 0, 1);
        chk("ovf cleared", int'(fifo_overflow), 0);
        step(0, 0, 0, 1, 1);
        chk("unf set beats clr", int'(fifo_underflow), 1);
        chk("unf ptr hold", int'(rbit), 0);

        // Asynchronous reset mid-traffic at level 5
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pre-rst level", int'(fifo_level), 5);
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 0, 0, 0);
        check_model("post rst write");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5);
            check_model($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_status.md
# fifo_ptr_status

Pointer and status stage of the FIFO datapath: directly downstream of the FIFO controller, it consumes the gated `fifo_we`/`fifo_rd` strobes and the `overflow_set`/`underflow_set` pulses. It maintains the write and read pointers and the occupancy level. It feeds `fifo_full`, `fifo_empty`, `fifo_threshold` and the read pointer (`rbit`) back to the controller, and holds sticky overflow/underflow error flags for software.

## Interface

Parameters:
- `ADDR_W`, 4: memory address width; depth = 2^ADDR_W (16).
- `THRESH`, 8: occupancy at or above which `fifo_threshold` asserts; legal range 1..2^ADDR_W.

Ports:
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `fifo_we`  input  1  accepted write strobe from controller (already gated by not-full).
- `fifo_rd`  input  1  accepted read strobe from controller (already gated by not-empty).
- `overflow_set`  input  1  write attempted while full.
- `underflow_set`  input  1  read attempted while empty.
- `err_clr`  input  1  synchronous clear of both sticky error flags.
- `wptr`  output  ADDR_W+1  write pointer; MSB is the wrap bit, LSBs are the memory write address.
- `rbit`  output  ADDR_W+1  read pointer; MSB is the wrap bit, LSBs are the memory read address.
- `fifo_level`  output  ADDR_W+1  occupancy, 0..2^ADDR_W.
- `fifo_full`  output  1  level == 2^ADDR_W.
- `fifo_empty`  output  1  level == 0.
- `fifo_threshold`  output  1  level >= THRESH.
- `fifo_overflow`  output  1  sticky overflow flag.
- `fifo_underflow`  output  1  sticky underflow flag.

## Operation

- Pointers:
  - `wptr` increments by 1 mod 2^(ADDR_W+1) on a cycle with `fifo_we & ~fifo_full`.
  - `rbit` increments likewise on a cycle with `fifo_rd & ~fifo_empty`.
  - The local full/empty qualification is defensive: a strobe against a full (or empty) FIFO is ignored, and pointers hold.
  - Wrap: the pointer goes from all-ones to all-zeros and the MSB toggles on each pass through the memory.
- Level: `fifo_level = wptr - rbit`, computed modulo 2^(ADDR_W+1), unsigned. Either registered or derived from the pointers, with identical cycle behaviour.
- Flags, all decoded from registered pointers only:
  - `fifo_empty` = (`wptr` == `rbit`).
  - `fifo_full` = (MSBs differ) & (LSBs equal).
  - `fifo_threshold` = `fifo_level` >= THRESH.
  - No combinational path from any input to these flags. This is mandatory: the controller gates strobes with these flags combinationally, so an input-to-flag path would form a loop.
- Simultaneous accepted write and read: both pointers advance; level and flags are unchanged.
- Sticky errors:
  - `fifo_overflow` sets on `overflow_set` and holds until `err_clr`; `fifo_underflow` behaves the same with `underflow_set`.
  - If set and clear occur in the same cycle, set wins (flag stays/becomes 1).
  - Error pulses never move the pointers.
- No data storage in this block. The memory uses `wptr[ADDR_W-1:0]` as write address and `rbit[ADDR_W-1:0]` as read address.

## Timing

- Reset (asynchronous assert, takes effect immediately):
  - `wptr`=0, `rbit`=0, `fifo_level`=0.
  - `fifo_empty`=1, `fifo_full`=0, `fifo_threshold`=0.
  - `fifo_overflow`=0, `fifo_underflow`=0.
- Reset mid-operation discards all contents and sticky state; the first strobe after deassertion acts on the reset state.
- Latency:
  - A strobe sampled at edge N updates pointers, level and flags right after edge N.
  - The controller sees the new `fifo_full`/`fifo_empty` for cycle N+1 gating.
  - Sticky flags likewise assert one edge after the `*_set` pulse.
- Back-to-back strobes every cycle are supported: one write and/or one read per clock, continuous.
- Boundaries:
  - Level 15 plus a write gives full on the next cycle.
  - At full, a write plus a read in the same cycle: the write is not accepted and the read is accepted, giving level 15 and full deasserted.
  - At empty, a write plus a read in the same cycle: the read is not accepted and the write is accepted, giving level 1.

## Test plan

- Reset then idle → `fifo_empty`=1, `fifo_full`=0, `fifo_threshold`=0, both pointers 0, both sticky flags 0. Assert `rst` mid-traffic at level 5 → all outputs return to reset values without waiting for a clock edge.
- 16 consecutive writes from empty → `fifo_threshold` rises after the 8th write edge; `fifo_full`=1 after the 16th; `wptr`=5'b10000, `fifo_level`=16.
- Fill to 16, then drain with 16 reads → `rbit` wraps to 5'b10000, `fifo_empty`=1, level 0. Repeat fill/drain twice more to check that MSB toggling keeps full/empty correct across wrap.
- At level 7, apply simultaneous `fifo_we`/`fifo_rd` for 20 cycles → level stays 7, `fifo_threshold` stays 0, and both pointers advance by 20 mod 32 (value 27).
- Force `fifo_we`=1 while full, and `fifo_rd`=1 while empty → pointers unchanged in both cases.
- Pulse `overflow_set` for 1 cycle → `fifo_overflow`=1 from the next edge and held for 10+ cycles; `err_clr` → 0. Then assert `underflow_set` and `err_clr` in the same cycle → `fifo_underflow`=1.
